image_mem_arbiter: RTL and testbench

Sequential arbiter sharing the single-port image RAM between the VGA pixel fetch path and the pipelined CPU's memory-mapped image accesses. VGA reads get priority so the display keeps streaming. The CPU uses a req/ack handshake and gets a bounded-wait slot through a starvation guard. The block sits between the display address generator, the CPU data-memory decoder and the RAM macro, which has synchronous read with 1-cycle latency.

---
 rtl/image_mem_arbiter.sv | 146 ++++++++++++++
 tb/tb_image_mem_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/image_mem_arbiter.sv
// Single-port image RAM arbiter: VGA pixel fetches have priority, CPU req/ack gets a bounded wait.
// Optional stall counter enabled by defining IMG_ARB_PERF_EN.
module image_mem_arbiter #(
  parameter int unsigned IMAGE_WORDS = 200000,
  parameter int unsigned MAX_WAIT    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        vga_req,
  input  logic [18:0] vga_addr,
  output logic        vga_valid,
  output logic [7:0]  vga_pixel,
  output logic        vga_miss,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [18:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_ack,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_err,
  output logic [18:0] mem_addr,
  output logic        mem_we,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic [15:0] perf_stall_cnt
);

  typedef enum logic [1:0] {StIdle, StCpuRd, StCpuAck} state_e;

  localparam logic [18:0] AddrLimit = 19'(IMAGE_WORDS);
  localparam logic [3:0]  WaitMax   = 4'(MAX_WAIT);

  state_e      state_q, state_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic        vga_inflight_q, vga_inflight_d;
  logic        vga_valid_q, vga_valid_d;
  logic [7:0]  vga_pixel_q, vga_pixel_d;
  logic        vga_miss_q, vga_miss_d;
  logic        cpu_ack_q, cpu_ack_d;
  logic [7:0]  cpu_rdata_q, cpu_rdata_d;
  logic        cpu_err_q, cpu_err_d;

  logic cpu_elig, cpu_oor, cpu_force, cpu_go, cpu_mem, cpu_lose, vga_go;

  // Out-of-range CPU accesses need no RAM slot, so they complete alongside a VGA fetch.
  always_comb begin
    cpu_elig  = rst_n && (state_q == StIdle) && cpu_req;
    cpu_oor   = cpu_addr >= AddrLimit;
    cpu_force = cpu_elig && (wait_cnt_q == WaitMax);
    cpu_go    = cpu_elig && (cpu_oor || cpu_force || !vga_req);
    cpu_mem   = cpu_go && !cpu_oor;
    cpu_lose  = cpu_elig && !cpu_go;
    vga_go    = rst_n && vga_req && !cpu_mem;
  end

  always_comb begin
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    if (cpu_mem) begin
      mem_addr  = cpu_addr;
      mem_we    = cpu_we;
      mem_wdata = cpu_we ? cpu_wdata : 8'h00;
    end else if (vga_go) begin
      mem_addr = vga_addr;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (cpu_go) state_d = (cpu_oor || cpu_we) ? StCpuAck : StCpuRd;
      end
      StCpuRd:  state_d = StCpuAck;
      StCpuAck: state_d = StIdle;
      default:  state_d = StIdle;
    endcase

    wait_cnt_d = wait_cnt_q;
    if (cpu_go) begin
      wait_cnt_d = '0;
    end else if (cpu_lose && (wait_cnt_q < WaitMax)) begin
      wait_cnt_d = wait_cnt_q + 4'd1;
    end

    cpu_ack_d   = (state_d == StCpuAck);
    cpu_err_d   = cpu_go && cpu_oor;
    cpu_rdata_d = (state_q == StCpuRd) ? mem_rdata : 8'h00;

    vga_inflight_d = vga_go;
    vga_valid_d    = vga_inflight_q;
    vga_pixel_d    = vga_inflight_q ? mem_rdata : vga_pixel_q;
    vga_miss_d     = vga_req && cpu_mem;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      wait_cnt_q     <= '0;
      vga_inflight_q <= 1'b0;
      vga_valid_q    <= 1'b0;
      vga_pixel_q    <= '0;
      vga_miss_q     <= 1'b0;
      cpu_ack_q      <= 1'b0;
      cpu_rdata_q    <= '0;
      cpu_err_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      wait_cnt_q     <= wait_cnt_d;
      vga_inflight_q <= vga_inflight_d;
      vga_valid_q    <= vga_valid_d;
      vga_pixel_q    <= vga_pixel_d;
      vga_miss_q     <= vga_miss_d;
      cpu_ack_q      <= cpu_ack_d;
      cpu_rdata_q    <= cpu_rdata_d;
      cpu_err_q      <= cpu_err_d;
    end
  end

  assign vga_valid = vga_valid_q;
  assign vga_pixel = vga_pixel_q;
  assign vga_miss  = vga_miss_q;
  assign cpu_ack   = cpu_ack_q;
  assign cpu_rdata = cpu_rdata_q;
  assign cpu_err   = cpu_err_q;

`ifdef IMG_ARB_PERF_EN
  logic [15:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    if (cpu_lose && (perf_q != 16'hFFFF)) perf_d = perf_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) perf_q <= '0;
    else        perf_q <= perf_d;
  end

  assign perf_stall_cnt = perf_q;
`else
  assign perf_stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_image_mem_arbiter.sv
// Directed bench for image_mem_arbiter with a 1-cycle synchronous-read RAM model.
module tb_image_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        vga_req;
  logic [18:0] vga_addr;
  logic        vga_valid;
  logic [7:0]  vga_pixel;
  logic        vga_miss;
  logic        cpu_req;
  logic        cpu_we;
  logic [18:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_ack;
  logic [7:0]  cpu_rdata;
  logic        cpu_err;
  logic [18:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic [15:0] perf_stall_cnt;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  image_mem_arbiter #(
    .IMAGE_WORDS(200000),
    .MAX_WAIT   (4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .vga_req       (vga_req),
    .vga_addr      (vga_addr),
    .vga_valid     (vga_valid),
    .vga_pixel     (vga_pixel),
    .vga_miss      (vga_miss),
    .cpu_req       (cpu_req),
    .cpu_we        (cpu_we),
    .cpu_addr      (cpu_addr),
    .cpu_wdata     (cpu_wdata),
    .cpu_ack       (cpu_ack),
    .cpu_rdata     (cpu_rdata),
    .cpu_err       (cpu_err),
    .mem_addr      (mem_addr),
    .mem_we        (mem_we),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata),
    .perf_stall_cnt(perf_stall_cnt)
  );

  // RAM model, preloaded with 8'h30 + address on its first clock.
  logic [7:0] ram [0:1023];
  logic       ram_init_done = 1'b0;

  always @(posedge clk) begin
    if (!ram_init_done) begin
      for (int i = 0; i < 1024; i++) ram[i] <= 8'h30 + 8'(i);
      ram_init_done <= 1'b1;
      mem_rdata     <= 8'h30;
    end else begin
      if (mem_we) ram[mem_addr[9:0]] <= mem_wdata;
      mem_rdata <= ram[mem_addr[9:0]];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    vga_req   = 1'b0;
    vga_addr  = '0;
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = '0;
    cpu_wdata = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests_run++;
    if ({vga_valid, vga_pixel, vga_miss, cpu_ack, cpu_rdata, cpu_err} !== 19'd0) begin
      tests_failed++;
      $display("FAIL reset_regs: got %b, required 0",
               {vga_valid, vga_pixel, vga_miss, cpu_ack, cpu_rdata, cpu_err});
    end
    tests_run++;
    if ({mem_addr, mem_we, mem_wdata, perf_stall_cnt} !== 44'd0) begin
      tests_failed++;
      $display("FAIL reset_mem: addr=%0d we=%b wdata=%h perf=%0d, required all 0",
               mem_addr, mem_we, mem_wdata, perf_stall_cnt);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_cpu_write();
    tick();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 19'd5; cpu_wdata = 8'hA5;
    @(negedge clk);
    tests_run++;
    if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 19'd5, 8'hA5}) begin
      tests_failed++;
      $display("FAIL wr_issue: we=%b addr=%0d wdata=%h, required 1/5/a5", mem_we, mem_addr,
               mem_wdata);
    end
    tick();
    cpu_req = 1'b0; cpu_we = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({cpu_ack, cpu_err, cpu_rdata} !== {1'b1, 1'b0, 8'h00}) begin
      tests_failed++;
      $display("FAIL wr_ack: ack=%b err=%b rdata=%h, required 1/0/00", cpu_ack, cpu_err,
               cpu_rdata);
    end
    tick();
    @(negedge clk);
    tests_run++;
    if (cpu_ack !== 1'b0) begin
      tests_failed++;
      $display("FAIL wr_ack_pulse: ack=%b, required 0", cpu_ack);
    end
  endtask

  task automatic test_cpu_read();
    tick();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 19'd5;
    @(negedge clk);
    tests_run++;
    if ({mem_we, mem_addr} !== {1'b0, 19'd5}) begin
      tests_failed++;
      $display("FAIL rd_issue: we=%b addr=%0d, required 0/5", mem_we, mem_addr);
    end
    tick();
    @(negedge clk);
    tests_run++;
    if (cpu_ack !== 1'b0) begin
      tests_failed++;
      $display("FAIL rd_early_ack: ack=%b, required 0", cpu_ack);
    end
    tick();
    cpu_req = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({cpu_ack, cpu_err, cpu_rdata} !== {1'b1, 1'b0, 8'hA5}) begin
      tests_failed++;
      $display("FAIL rd_ack: ack=%b err=%b rdata=%h, required 1/0/a5", cpu_ack, cpu_err,
               cpu_rdata);
    end
  endtask

  task automatic test_vga_stream();
    logic [7:0] exp_pix;
    logic       exp_valid;
    for (int c = 0; c <= 12; c++) begin
      tick();
      vga_req  = (c < 10);
      vga_addr = (c < 10) ? 19'(c) : 19'd0;
      @(negedge clk);
      exp_valid = (c >= 2) && (c <= 11);
      tests_run++;
      if (vga_valid !== exp_valid) begin
        tests_failed++;
        $display("FAIL vga_valid c%0d: got %b, required %b", c, vga_valid, exp_valid);
      end
      if (exp_valid) begin
        exp_pix = (c - 2 == 5) ? 8'hA5 : 8'h30 + 8'(c - 2);
        tests_run++;
        if (vga_pixel !== exp_pix) begin
          tests_failed++;
          $display("FAIL vga_pixel c%0d: got %h, required %h", c, vga_pixel, exp_pix);
        end
      end
    end
  endtask

  task automatic test_starvation();
    for (int c = 0; c <= 6; c++) begin
      tick();
      if (c == 0) begin
        vga_req = 1'b1; vga_addr = 19'd0;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 19'd7; cpu_wdata = 8'h5A;
      end
      if (c == 5) begin
        cpu_req = 1'b0; cpu_we = 1'b0;
      end
      if (c == 6) vga_req = 1'b0;
      @(negedge clk);
      if (c <= 4) begin
        tests_run++;
        if (mem_we !== (c == 4)) begin
          tests_failed++;
          $display("FAIL starve_we c%0d: got %b, required %b", c, mem_we, (c == 4));
        end
        tests_run++;
        if (cpu_ack !== 1'b0) begin
          tests_failed++;
          $display("FAIL starve_early_ack c%0d: got %b, required 0", c, cpu_ack);
        end
      end
      if (c == 5) begin
        tests_run++;
        if ({cpu_ack, cpu_err, vga_miss} !== 3'b101) begin
          tests_failed++;
          $display("FAIL starve_ack: ack=%b err=%b miss=%b, required 1/0/1", cpu_ack, cpu_err,
                   vga_miss);
        end
        tests_run++;
`ifdef IMG_ARB_PERF_EN
        if (perf_stall_cnt !== 16'd4) begin
          tests_failed++;
          $display("FAIL starve_perf: got %0d, required 4", perf_stall_cnt);
        end
`else
        if (perf_stall_cnt !== 16'd0) begin
          tests_failed++;
          $display("FAIL starve_perf: got %0d, required 0", perf_stall_cnt);
        end
`endif
      end
      if (c == 6) begin
        tests_run++;
        if ({vga_valid, vga_miss, vga_pixel} !== {1'b0, 1'b0, 8'h30}) begin
          tests_failed++;
          $display("FAIL starve_drop: valid=%b miss=%b pixel=%h, required 0/0/30", vga_valid,
                   vga_miss, vga_pixel);
        end
      end
    end
    tick();
    tick();
  endtask

  task automatic test_out_of_range();
    tick();
    vga_req = 1'b1; vga_addr = 19'd2;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 19'd200000;
    @(negedge clk);
    tests_run++;
    if ({mem_we, mem_addr} !== {1'b0, 19'd2}) begin
      tests_failed++;
      $display("FAIL oor_slot: we=%b addr=%0d, required 0/2", mem_we, mem_addr);
    end
    tick();
    vga_req = 1'b0; cpu_req = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({cpu_ack, cpu_err, cpu_rdata, mem_we} !== {1'b1, 1'b1, 8'h00, 1'b0}) begin
      tests_failed++;
      $display("FAIL oor_ack: ack=%b err=%b rdata=%h we=%b, required 1/1/00/0", cpu_ack,
               cpu_err, cpu_rdata, mem_we);
    end
    tick();
    @(negedge clk);
    tests_run++;
    if ({vga_valid, vga_pixel} !== {1'b1, 8'h32}) begin
      tests_failed++;
      $display("FAIL oor_vga: valid=%b pixel=%h, required 1/32", vga_valid, vga_pixel);
    end
  endtask

  task automatic test_reset_mid_read();
    tick();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 19'd3;
    tick();
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({cpu_ack, cpu_rdata, cpu_err, mem_addr, mem_we, vga_valid} !== 31'd0) begin
      tests_failed++;
      $display("FAIL mid_reset_outs: ack=%b rdata=%h err=%b addr=%0d we=%b valid=%b, required 0",
               cpu_ack, cpu_rdata, cpu_err, mem_addr, mem_we, vga_valid);
    end
    cpu_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      @(negedge clk);
      tests_run++;
      if (cpu_ack !== 1'b0) begin
        tests_failed++;
        $display("FAIL mid_reset_no_ack c%0d: got %b, required 0", c, cpu_ack);
      end
    end
    tick();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 19'd3;
    tick();
    tick();
    cpu_req = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({cpu_ack, cpu_err, cpu_rdata} !== {1'b1, 1'b0, 8'h33}) begin
      tests_failed++;
      $display("FAIL mid_reset_reread: ack=%b err=%b rdata=%h, required 1/0/33", cpu_ack,
               cpu_err, cpu_rdata);
    end
  endtask

  initial begin
    test_reset();
    test_cpu_write();
    test_cpu_read();
    test_vga_stream();
    test_starvation();
    test_out_of_range();
    test_reset_mid_read();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
